// File: rtl/lvds_pkg.sv
// rtl/lvds_pkg.sv - shared widths, state encoding and helpers for the link monitor
// Purpose : common definitions imported by link_monitor and lm_window.
// Contents: ERR_W / RECV_W / WIN_ERR_W counter widths, lm_state_e FSM encoding,
//           sat_err() clamp of a 64-bit error delta to the 32-bit window count.
package lvds_pkg;

  localparam int ERR_W     = 64;
  localparam int RECV_W    = 58;
  localparam int WIN_ERR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_LOST    = 3'd4
  } lm_state_e;

  function automatic logic [WIN_ERR_W-1:0] sat_err(input logic [ERR_W-1:0] d);
    sat_err = (|d[ERR_W-1:WIN_ERR_W]) ? '1 : d[WIN_ERR_W-1:0];
  endfunction

endpackage

// File: rtl/lm_window.sv
// rtl/lm_window.sv - window slicer: bases, modular deltas, close detection
// Purpose : tracks the counter bases of the current window, detects when
//           2^WIN_LOG2 words have been received and reports the clamped
//           error delta of the window that just closed.
// Ports   : CLKP/RSTXP   clock, asynchronous active-low reset
//           load_i       reload bases from the inputs every cycle (monitor idle)
//           active_i     window detection enabled (ACQUIRE/LOCKED)
//           err_cnt_i    cumulative lane error count
//           recv_cnt_i   cumulative lane received-word count
//           close_o      one-cycle pulse, registered, one edge after the close
//           d_o          clamped error count of the closed window
module lm_window
  import lvds_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 20
) (
  input  logic                 CLKP,
  input  logic                 RSTXP,
  input  logic                 load_i,
  input  logic                 active_i,
  input  logic [ERR_W-1:0]     err_cnt_i,
  input  logic [RECV_W-1:0]    recv_cnt_i,
  output logic                 close_o,
  output logic [WIN_ERR_W-1:0] d_o
);

  localparam logic [RECV_W-1:0] WIN_LEN = RECV_W'(1) << WIN_LOG2;

  logic [ERR_W-1:0]     err_base_q;
  logic [RECV_W-1:0]    recv_base_q;
  logic                 close_q;
  logic [WIN_ERR_W-1:0] d_q;
  logic [ERR_W-1:0]     err_delta;
  logic [RECV_W-1:0]    recv_delta;
  logic                 hit;

  // Subtraction wraps at the counter width, so lane counter roll-over is harmless.
  assign err_delta  = err_cnt_i - err_base_q;
  assign recv_delta = recv_cnt_i - recv_base_q;
  assign hit        = active_i && (recv_delta >= WIN_LEN);

  // Bases restart from the live counters rather than base+window so that a
  // window never inherits the overshoot of the previous one.
  always_ff @(posedge CLKP or negedge RSTXP) begin
    if (!RSTXP) begin
      err_base_q  <= '0;
      recv_base_q <= '0;
      close_q     <= 1'b0;
      d_q         <= '0;
    end else begin
      close_q <= hit;
      if (load_i || hit) begin
        err_base_q  <= err_cnt_i;
        recv_base_q <= recv_cnt_i;
      end
      if (hit) begin
        d_q <= sat_err(err_delta);
      end
    end
  end

  assign close_o = close_q;
  assign d_o     = d_q;

endmodule

// File: rtl/link_monitor.sv
// rtl/link_monitor.sv - link-quality supervisor with lock/loss FSM and snapshot port
// Purpose : grades fixed windows of received words, runs IDLE/CLEAR/ACQUIRE/
//           LOCKED/LOST, re-clears the lane on degradation and offers a
//           four-phase coherent snapshot of the two lane counters.
// Macro   : LINK_MONITOR_STALL_EN - adds a RECV_CNT stall detector that forces
//           LOST after STALL_CYC unchanged cycles in ACQUIRE/LOCKED.
// Ports   : CLKP/RSTXP           clock, asynchronous active-low reset
//           ENABLE               monitor enable, low forces IDLE
//           ERR_CNT/RECV_CNT     cumulative lane counters
//           CLR                  registered counter clear to the lane
//           STATE/LINK_UP        FSM state and lock indication
//           WIN_VALID/WIN_ERR    window-close pulse and its error count
//           BAD_WIN_CNT          saturating bad-window total since CLEAR
//           SNAP_REQ/SNAP_ACK    four-phase snapshot handshake
//           SNAP_ERR/SNAP_RECV   captured counters
module link_monitor
  import lvds_pkg::*;
#(
  parameter int unsigned WIN_LOG2  = 20,
  parameter int unsigned LOCK_WINS = 4,
  parameter int unsigned BAD_THR   = 16,
  parameter int unsigned LOST_WINS = 2,
  parameter int unsigned CLR_CYC   = 8,
  parameter int unsigned STALL_CYC = 1024
) (
  input  logic                 CLKP,
  input  logic                 RSTXP,
  input  logic                 ENABLE,
  input  logic [ERR_W-1:0]     ERR_CNT,
  input  logic [RECV_W-1:0]    RECV_CNT,
  output logic                 CLR,
  output logic [2:0]           STATE,
  output logic                 LINK_UP,
  output logic                 WIN_VALID,
  output logic [WIN_ERR_W-1:0] WIN_ERR,
  output logic [15:0]          BAD_WIN_CNT,
  input  logic                 SNAP_REQ,
  output logic                 SNAP_ACK,
  output logic [ERR_W-1:0]     SNAP_ERR,
  output logic [RECV_W-1:0]    SNAP_RECV
);

  lm_state_e            state_q, state_d;
  logic                 clr_q, clr_d;
  logic                 link_up_q, link_up_d;
  logic                 win_valid_q, win_valid_d;
  logic [WIN_ERR_W-1:0] win_err_q, win_err_d;
  logic [15:0]          bad_win_cnt_q, bad_win_cnt_d;
  logic [7:0]           cyc_q, cyc_d;
  logic [3:0]           clean_run_q, clean_run_d;
  logic [3:0]           bad_run_q, bad_run_d;
  logic                 snap_ack_q, snap_ack_d;
  logic [ERR_W-1:0]     snap_err_q, snap_err_d;
  logic [RECV_W-1:0]    snap_recv_q, snap_recv_d;

  logic                 active;
  logic                 win_close;
  logic [WIN_ERR_W-1:0] win_d;
  logic                 win_bad;
  logic                 stall;
  logic                 grade;

  assign active  = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
  assign win_bad = (win_d > WIN_ERR_W'(BAD_THR));

  lm_window #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .CLKP       (CLKP),
    .RSTXP      (RSTXP),
    .load_i     (!active),
    .active_i   (active),
    .err_cnt_i  (ERR_CNT),
    .recv_cnt_i (RECV_CNT),
    .close_o    (win_close),
    .d_o        (win_d)
  );

`ifdef LINK_MONITOR_STALL_EN
  localparam int unsigned STALL_W = $clog2(STALL_CYC + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RECV_W-1:0]  recv_prev_q;
  logic               recv_same;

  assign recv_same = (RECV_CNT == recv_prev_q);
  // Fires on the STALL_CYC-th consecutive unchanged cycle after the last change.
  assign stall = active && recv_same && (stall_cnt_q == STALL_W'(STALL_CYC - 1));

  always_comb begin
    stall_cnt_d = stall_cnt_q + STALL_W'(1);
    if (!active || !recv_same || (state_d != state_q)) begin
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge CLKP or negedge RSTXP) begin
    if (!RSTXP) begin
      stall_cnt_q <= '0;
      recv_prev_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      recv_prev_q <= RECV_CNT;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // A close is graded only while still supervising; a simultaneous stall or
  // ENABLE drop discards it.
  assign grade = win_close && active && ENABLE && !stall;

  always_comb begin
    state_d       = state_q;
    cyc_d         = '0;
    clean_run_d   = clean_run_q;
    bad_run_d     = bad_run_q;
    bad_win_cnt_d = bad_win_cnt_q;
    win_valid_d   = 1'b0;
    win_err_d     = win_err_q;
    snap_ack_d    = snap_ack_q;
    snap_err_d    = snap_err_q;
    snap_recv_d   = snap_recv_q;

    if (grade) begin
      win_valid_d = 1'b1;
      win_err_d   = win_d;
      if (win_bad && (bad_win_cnt_q != 16'hFFFF)) begin
        bad_win_cnt_d = bad_win_cnt_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cyc_d         = cyc_q + 8'd1;
        clean_run_d   = '0;
        bad_run_d     = '0;
        bad_win_cnt_d = '0;
        if (cyc_q == 8'(CLR_CYC - 1)) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (grade) begin
          if (win_bad) begin
            clean_run_d = '0;
          end else begin
            clean_run_d = clean_run_q + 4'd1;
            if ((clean_run_q + 4'd1) == 4'(LOCK_WINS)) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (grade) begin
          if (win_bad) begin
            bad_run_d = bad_run_q + 4'd1;
            if ((bad_run_q + 4'd1) == 4'(LOST_WINS)) state_d = ST_LOST;
          end else begin
            bad_run_d = '0;
          end
        end
      end
      ST_LOST: begin
        state_d = ST_CLEAR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stall) state_d = ST_LOST;
    if (!ENABLE) state_d = ST_IDLE;

    // Outputs follow the next state so CLR and LINK_UP switch with STATE.
    clr_d     = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
    link_up_d = (state_d == ST_LOCKED);

    if (!snap_ack_q && SNAP_REQ) begin
      snap_ack_d  = 1'b1;
      snap_err_d  = ERR_CNT;
      snap_recv_d = RECV_CNT;
    end else if (snap_ack_q && !SNAP_REQ) begin
      snap_ack_d = 1'b0;
    end
  end

  always_ff @(posedge CLKP or negedge RSTXP) begin
    if (!RSTXP) begin
      state_q       <= ST_IDLE;
      clr_q         <= 1'b1;
      link_up_q     <= 1'b0;
      win_valid_q   <= 1'b0;
      win_err_q     <= '0;
      bad_win_cnt_q <= '0;
      cyc_q         <= '0;
      clean_run_q   <= '0;
      bad_run_q     <= '0;
      snap_ack_q    <= 1'b0;
      snap_err_q    <= '0;
      snap_recv_q   <= '0;
    end else begin
      state_q       <= state_d;
      clr_q         <= clr_d;
      link_up_q     <= link_up_d;
      win_valid_q   <= win_valid_d;
      win_err_q     <= win_err_d;
      bad_win_cnt_q <= bad_win_cnt_d;
      cyc_q         <= cyc_d;
      clean_run_q   <= clean_run_d;
      bad_run_q     <= bad_run_d;
      snap_ack_q    <= snap_ack_d;
      snap_err_q    <= snap_err_d;
      snap_recv_q   <= snap_recv_d;
    end
  end

  assign CLR         = clr_q;
  assign STATE       = state_q;
  assign LINK_UP     = link_up_q;
  assign WIN_VALID   = win_valid_q;
  assign WIN_ERR     = win_err_q;
  assign BAD_WIN_CNT = bad_win_cnt_q;
  assign SNAP_ACK    = snap_ack_q;
  assign SNAP_ERR    = snap_err_q;
  assign SNAP_RECV   = snap_recv_q;

endmodule
